// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, countdown
// width and a byte-lane expansion helper.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Wide enough for a LATENCY-1 load of up to 14.
  localparam int CNT_W = 4;

  // Expand a 4-bit byte-lane enable into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] mask);
    logic [31:0] m;
    for (int n = 0; n < 4; n++) begin
      m[8*n +: 8] = {8{mask[n]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a requester (master) and the memory
// responder (slave). Signal names carry the responder's port direction.
interface mem_responder_if;

  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_ren;
  logic        i_req_wen;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_mask;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_ren, i_req_wen, i_req_wdata,
           i_req_mask, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_ren, i_req_wen, i_req_wdata,
           i_req_mask, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

endinterface

// File: rtl/mem_array.sv
// Word storage: synchronous byte-enabled write, combinational read.
// Contents are deliberately not reset so they survive a responder reset.
module mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          i_clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [0:DEPTH_WORDS-1];

  // Byte-lane write: only enabled lanes of the addressed word change.
  always_ff @(posedge i_clk) begin
    for (int n = 0; n < 4; n++) begin
      if (i_we[n]) begin
        r_mem[i_addr][8*n +: 8] <= i_wdata[8*n +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request at a time, commits
// writes / samples reads on the acceptance edge, then presents the
// response LATENCY cycles later and holds it until taken.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  mem_responder_if.slave  bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_err;
  logic [31:0]      r_data;
  logic             r_err;

  logic [31:0]      w_off;
  logic [31:0]      w_idx;
  logic             w_err;
  logic             w_acc;
  logic [3:0]       w_we;
  logic [AW-1:0]    w_word;
  logic [31:0]      w_mem_rdata;
  logic [31:0]      w_cap;

  // Error decode: misaligned, outside the window, or not exactly one of ren/wen.
  assign w_off  = bus.i_req_addr - BASE_ADDR;
  assign w_idx  = w_off >> 2;
  assign w_err  = (bus.i_req_addr[1:0] != 2'b00)
               || (bus.i_req_addr < BASE_ADDR)
               || (w_idx >= 32'(DEPTH_WORDS))
               || (bus.i_req_ren == bus.i_req_wen);
  assign w_word = w_idx[AW-1:0];

  assign w_acc  = bus.i_req_valid && (r_state == ST_IDLE);
  assign w_we   = (w_acc && !w_err && bus.i_req_wen) ? bus.i_req_mask : 4'b0000;
  // Writes and errors return zero; reads return only the masked lanes.
  assign w_cap  = (w_err || bus.i_req_wen) ? 32'h0
                : (w_mem_rdata & lane_mask(bus.i_req_mask));

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_addr  (w_word),
    .i_wdata (bus.i_req_wdata),
    .o_rdata (w_mem_rdata)
  );

  // Request/response sequencing: accept in IDLE, count out LATENCY, hold response until taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_data      <= 32'h0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_req_ready <= 1'b0;
            if (LATENCY == 1) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_cap;
              r_rsp_err   <= w_err;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_W'(LATENCY - 1);
              r_data  <= w_cap;
              r_err   <= w_err;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          // The countdown reaching zero on this edge releases the response.
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_data;
            r_rsp_err   <= r_err;
          end
        end
        ST_RESP: begin
          if (bus.i_rsp_ready) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= 32'h0;
          r_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_req_ready = r_req_ready;
  assign bus.o_rsp_valid = r_rsp_valid;
  assign bus.o_rsp_rdata = r_rsp_rdata;
  assign bus.o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=2 instance (sel=0) and a LATENCY=1
// instance (sel=1) share request wires; a word-array model predicts
// every response from the address/mask/ren/wen rules.
module tb_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr  = '0;
  logic        req_ren   = 1'b0;
  logic        req_wen   = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_mask  = '0;
  logic        rsp_ready = 1'b0;

  logic        o_ready, o_valid, o_err;
  logic [31:0] o_rdata;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_rd;
  logic        exp_err;
  logic [31:0] model [2][DEPTH];

  always #5 clk = ~clk;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  assign bus0.i_req_valid = req_valid && !sel;
  assign bus1.i_req_valid = req_valid && sel;
  assign bus0.i_rsp_ready = rsp_ready && !sel;
  assign bus1.i_rsp_ready = rsp_ready && sel;
  assign bus0.i_req_addr  = req_addr;
  assign bus1.i_req_addr  = req_addr;
  assign bus0.i_req_ren   = req_ren;
  assign bus1.i_req_ren   = req_ren;
  assign bus0.i_req_wen   = req_wen;
  assign bus1.i_req_wen   = req_wen;
  assign bus0.i_req_wdata = req_wdata;
  assign bus1.i_req_wdata = req_wdata;
  assign bus0.i_req_mask  = req_mask;
  assign bus1.i_req_mask  = req_mask;

  assign o_ready = sel ? bus1.o_req_ready : bus0.o_req_ready;
  assign o_valid = sel ? bus1.o_rsp_valid : bus0.o_rsp_valid;
  assign o_rdata = sel ? bus1.o_rsp_rdata : bus0.o_rsp_rdata;
  assign o_err   = sel ? bus1.o_rsp_err   : bus0.o_rsp_err;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(32'h0)) dut0 (
    .i_clk (clk), .i_rst (rst), .bus (bus0.slave));

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(32'h0)) dut1 (
    .i_clk (clk), .i_rst (rst), .bus (bus1.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one accepted request on instance d.
  task automatic model_req(input int d, input logic [31:0] a, input logic r, input logic w,
                           input logic [31:0] wd, input logic [3:0] m,
                           output logic [31:0] erd, output logic eerr);
    int idx;
    erd  = 32'h0;
    eerr = (a[1:0] != 2'b00) || (r == w) || ((a >> 2) >= DEPTH);
    if (!eerr) begin
      idx = int'(a >> 2);
      for (int b = 0; b < 4; b++) begin
        if (m[b]) begin
          if (w) model[d][idx][8*b +: 8] = wd[8*b +: 8];
          else   erd[8*b +: 8] = model[d][idx][8*b +: 8];
        end
      end
    end
  endtask

  task automatic present(input logic [31:0] a, input logic r, input logic w,
                         input logic [31:0] wd, input logic [3:0] m);
    req_addr = a; req_ren = r; req_wen = w; req_wdata = wd; req_mask = m;
    req_valid = 1'b1;
  endtask

  // Called #1 after an edge with a request already presented and ready high.
  task automatic accept(input string tag);
    check({tag, ".ready"}, 32'(o_ready), 32'd1);
    @(posedge clk);
    model_req(int'(sel), req_addr, req_ren, req_wen, req_wdata, req_mask, exp_rd, exp_err);
    #1;
  endtask

  task automatic await_rsp(input string tag);
    int lat;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"},   32'(lat), sel ? 32'd1 : 32'd2);
    check({tag, ".rdata"}, o_rdata, exp_rd);
    check({tag, ".err"},   32'(o_err), 32'(exp_err));
  endtask

  task automatic hold_rsp(input string tag, input int n);
    for (int h = 0; h < n; h++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(o_valid), 32'd1);
      check({tag, ".hold_rdata"}, o_rdata, exp_rd);
      check({tag, ".hold_ready"}, 32'(o_ready), 32'd0);
    end
  endtask

  task automatic release_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(o_valid), 32'd0);
    check({tag, ".post_rdata"}, o_rdata, 32'h0);
    check({tag, ".post_err"},   32'(o_err), 32'd0);
    check({tag, ".post_ready"}, 32'(o_ready), 32'd1);
  endtask

  task automatic txn(input string tag, input logic [31:0] a, input logic r, input logic w,
                     input logic [31:0] wd, input logic [3:0] m, input int hold);
    present(a, r, w, wd, m);
    accept(tag);
    req_valid = 1'b0;
    await_rsp(tag);
    hold_rsp(tag, hold);
    release_rsp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] a, wd;
    logic [3:0]  m;
    logic        r, w;
    int          kind;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 32'(bus0.o_req_ready), 32'd1);
    check("rst.valid", 32'(bus0.o_rsp_valid), 32'd0);
    check("rst.rdata", bus0.o_rsp_rdata, 32'h0);
    check("rst.err",   32'(bus0.o_rsp_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full write and read-back
    txn("full_wr", 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, 0);
    txn("full_rd", 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 0);
    check("full_rd.value", exp_rd, 32'hDEADBEEF);

    // Byte-lane write
    txn("lane_wr0", 32'h20, 1'b0, 1'b1, 32'h11223344, 4'hF, 0);
    txn("lane_wr1", 32'h20, 1'b0, 1'b1, 32'hAA000000, 4'h8, 1);
    txn("lane_rdF", 32'h20, 1'b1, 1'b0, 32'h0, 4'hF, 0);
    check("lane_rdF.value", exp_rd, 32'hAA223344);
    txn("lane_rd3", 32'h20, 1'b1, 1'b0, 32'h0, 4'h3, 0);
    check("lane_rd3.value", exp_rd, 32'h00003344);
    txn("lane_rd0", 32'h20, 1'b1, 1'b0, 32'h0, 4'h0, 0);

    // Error cases; word 0x20 must be untouched
    txn("err_misal", 32'h22, 1'b0, 1'b1, 32'hFFFFFFFF, 4'hF, 0);
    txn("err_oob",   32'(DEPTH * 4), 1'b0, 1'b1, 32'hFFFFFFFF, 4'hF, 0);
    txn("err_both",  32'h20, 1'b1, 1'b1, 32'hFFFFFFFF, 4'hF, 0);
    txn("err_none",  32'h20, 1'b0, 1'b0, 32'hFFFFFFFF, 4'hF, 0);
    txn("err_reread", 32'h20, 1'b1, 1'b0, 32'h0, 4'hF, 0);
    check("err_reread.value", exp_rd, 32'hAA223344);

    // Backpressure with a second request held pending
    present(32'h10, 1'b1, 1'b0, 32'h0, 4'hF);
    accept("bp_rd");
    present(32'h10, 1'b0, 1'b1, 32'h55555555, 4'hF);
    await_rsp("bp_rd");
    hold_rsp("bp_rd", 5);
    release_rsp("bp_rd");
    @(posedge clk);
    model_req(0, req_addr, req_ren, req_wen, req_wdata, req_mask, exp_rd, exp_err);
    #1;
    req_valid = 1'b0;
    await_rsp("bp_wr");
    release_rsp("bp_wr");
    txn("bp_reread", 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 0);
    check("bp_reread.value", exp_rd, 32'h55555555);

    // Reset while a read waits
    txn("rst_wr", 32'h30, 1'b0, 1'b1, 32'h0000CAFE, 4'hF, 0);
    present(32'h30, 1'b1, 1'b0, 32'h0, 4'hF);
    accept("rst_rd");
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst.ready", 32'(o_ready), 32'd1);
    check("midrst.valid", 32'(o_valid), 32'd0);
    check("midrst.rdata", o_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("midrst.no_rsp", 32'(o_valid), 32'd0);
    end
    txn("rst_reread", 32'h30, 1'b1, 1'b0, 32'h0, 4'hF, 0);
    check("rst_reread.value", exp_rd, 32'h0000CAFE);

    // Minimum latency instance
    sel = 1'b1;
    #1;
    txn("lat1_wr", 32'h8, 1'b0, 1'b1, 32'h12345678, 4'hF, 0);
    txn("lat1_rd", 32'h8, 1'b1, 1'b0, 32'h0, 4'hF, 0);
    check("lat1_rd.value", exp_rd, 32'h12345678);
    txn("lat1_rd5", 32'h8, 1'b1, 1'b0, 32'h0, 4'h5, 2);

    // Random traffic over eight words on both instances
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      for (int i = 0; i < 8; i++) begin
        txn("rnd_init", 32'(32'h40 + 4 * i), 1'b0, 1'b1, $urandom, 4'hF, 0);
      end
    end
    for (int t = 0; t < 60; t++) begin
      sel = ($urandom_range(0, 3) == 0);
      #1;
      a    = 32'(32'h40 + 4 * $urandom_range(0, 7));
      m    = 4'($urandom_range(0, 15));
      wd   = $urandom;
      kind = $urandom_range(0, 9);
      r = 1'b1; w = 1'b0;
      case (kind)
        0: begin r = 1'b1; w = 1'b1; end
        1: begin r = 1'b0; w = 1'b0; end
        2: a = a | 32'($urandom_range(1, 3));
        7, 8, 9: begin r = 1'b0; w = 1'b1; end
        default: ;
      endcase
      txn("rnd", a, r, w, wd, m, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to response valid; legal range 1..15.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h00000000: byte address of word 0.
REQ-004 SHALL have one clock; reset is asynchronous and active-high. Ports: i_clk  in  1  clock; i_rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have i_req_valid  in  1  request present.
REQ-006 SHALL have o_req_ready  out  1  responder can accept a request.
REQ-007 SHALL have i_req_addr  in  32  byte address, expected word-aligned.
REQ-008 SHALL have i_req_ren  in  1  read request.
REQ-009 SHALL have i_req_wen  in  1  write request.
REQ-010 SHALL have i_req_wdata  in  32  write data, already lane-shifted by the hart.
REQ-011 SHALL have i_req_mask  in  4  byte-lane enables; bit n maps to bits [8n+7:8n].
REQ-012 SHALL have o_rsp_valid  out  1  response present.
REQ-013 SHALL have i_rsp_ready  in  1  requester accepts the response.
REQ-014 SHALL have o_rsp_rdata  out  32  read data; bytes outside the mask read as zero.
REQ-015 SHALL have o_rsp_err  out  1  request was illegal; no memory side effect.

Function
REQ-016 SHALL accept a request on a rising edge where i_req_valid && o_req_ready.
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; o_req_ready=1 only in IDLE; o_rsp_valid=1 only in RESP.
REQ-018 SHALL go IDLE->RESP directly on acceptance when LATENCY=1; otherwise IDLE->WAIT, loading a countdown of LATENCY-1.
REQ-019 SHALL move WAIT->RESP when the countdown reaches zero, so o_rsp_valid rises exactly LATENCY cycles after the acceptance cycle.
REQ-020 SHALL hold o_rsp_valid, o_rsp_rdata and o_rsp_err stable in RESP until i_rsp_ready=1, then return to IDLE on that edge; o_req_ready reasserts on the following cycle (no same-cycle back-to-back).
REQ-021 SHALL flag an error when i_req_addr[1:0]!=0, the word index ((addr-BASE_ADDR)>>2) is >= DEPTH_WORDS or addr<BASE_ADDR, i_req_ren==i_req_wen (both or neither).
REQ-022 SHALL commit a legal write on the acceptance edge, updating only the masked byte lanes; o_rsp_rdata=0 for writes.
REQ-023 SHALL capture legal read data on the acceptance edge, zeroing unmasked lanes; a mask of 4'b0000 is legal and yields rdata=0, no write.
REQ-024 SHALL perform no write and return o_rsp_rdata=0 with o_rsp_err=1 for an erroneous request, still honouring LATENCY and the response handshake.
REQ-025 SHALL ignore all request inputs while not in IDLE.
REQ-026 SHALL drive o_rsp_rdata=0 and o_rsp_err=0 whenever o_rsp_valid=0.

Reset
REQ-027 SHALL, while i_rst=1, force state IDLE, countdown 0, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
REQ-028 SHALL discard any in-flight request on reset without issuing its response; a write committed before reset remains committed.
REQ-029 SHALL NOT reset the storage array; contents are retained across reset.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE, WAIT, RESP) and the countdown width constant in shared package mem_pkg.
REQ-031 SHALL instantiate one sub-module mem_array: DEPTH_WORDS x 32 synchronous-write, combinational-read storage with 4-bit byte write enable.
REQ-032 SHALL keep the FSM, error decode and response registers in mem_responder itself.

Verification
REQ-033 SHALL test a full write: LATENCY=2, write addr 0x10, mask 4'b1111, wdata 0xDEADBEEF, then read addr 0x10 -> rsp_valid 2 cycles after each acceptance, rdata 0xDEADBEEF, err 0.
REQ-034 SHALL test a byte-lane write: write addr 0x20 with 0x11223344, then mask 4'b1000, wdata 0xAA000000, then read with mask 4'b1111 -> rdata 0xAA223344; read with mask 4'b0011 -> 0x00003344.
REQ-035 SHALL test error cases: addr 0x22, addr (DEPTH_WORDS*4), and ren=wen=1 -> err 1, rdata 0, and the target word is unchanged on re-read.
REQ-036 SHALL test backpressure: hold i_rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable, req_ready 0, and a second i_req_valid is not accepted until the cycle after the handshake.
REQ-037 SHALL test reset mid-operation: assert i_rst in WAIT after a read is accepted -> no response is ever issued, req_ready=1 immediately, and a previously written 0x0000CAFE at 0x30 still reads back.
REQ-038 SHALL test minimum latency: LATENCY=1, read -> rsp_valid in the cycle immediately after acceptance.
